// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types: cell index/button widths,
// position-encoder FSM encoding and a cell-mask helper.
package ttt_pkg;

  localparam int CELL_IDX_W = 4;
  localparam int BTN_W      = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    VALID    = 2'd2,
    RELEASE  = 2'd3
  } enc_state_e;

  // Bits 0..n-1 set; n is clamped to BTN_W.
  function automatic logic [BTN_W-1:0] cell_mask(input int n);
    logic [BTN_W-1:0] m;
    m = '0;
    for (int i = 0; i < BTN_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Combinational 16->4 encoder with one-hot / multi-bit flags.
// Ports: vec in, idx out, is_onehot out, is_multi out.
module onehot_to_index
  import ttt_pkg::*;
(
  input  logic [BTN_W-1:0]      vec,
  output logic [CELL_IDX_W-1:0] idx,
  output logic                  is_onehot,
  output logic                  is_multi
);

  logic [BTN_W-1:0] low_clr;

  // OR of set-bit positions; exact for one-hot inputs.
  always_comb begin
    idx = '0;
    for (int i = 0; i < BTN_W; i++) begin
      if (vec[i]) idx = idx | CELL_IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something iff >=2 bits.
  assign low_clr   = vec & (vec - BTN_W'(1));
  assign is_multi  = |low_clr;
  assign is_onehot = (|vec) & ~is_multi;

endmodule

// File: rtl/position_encoder.sv
// Button-to-cell-index encoder: sync, debounce, valid/ready handoff.
// Ports: clk, rst_n, enable, btn_in, pos_out/pos_valid/pos_ready, multi_err, busy.
module position_encoder
  import ttt_pkg::*;
#(
  parameter int NUM_CELLS       = 9,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [BTN_W-1:0]      btn_in,
  output logic [CELL_IDX_W-1:0] pos_out,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic                  multi_err,
  output logic                  busy
);

  localparam logic [BTN_W-1:0] CELL_MASK = cell_mask(NUM_CELLS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [BTN_W-1:0]      sync1_q, sync2_q;
  logic [BTN_W-1:0]      m;
  logic [CELL_IDX_W-1:0] m_idx;
  logic                  m_onehot, m_multi;

  enc_state_e            state_q, state_d;
  logic [BTN_W-1:0]      cand_q, cand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CELL_IDX_W-1:0] pos_q, pos_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign m = sync2_q & CELL_MASK;

  // At accept time m==cand, so encoding m yields index(cand).
  onehot_to_index u_enc (
    .vec       (m),
    .idx       (m_idx),
    .is_onehot (m_onehot),
    .is_multi  (m_multi)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && m_onehot) begin
          cand_d  = m;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else if (enable && m_multi) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end
      DEBOUNCE: begin
        if (!enable || (m != cand_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          pos_d   = m_idx;
          state_d = VALID;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VALID: begin
        if (pos_ready) state_d = RELEASE;
      end
      RELEASE: begin
        if (m == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == VALID);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign pos_out   = pos_q;
  assign pos_valid = valid_q;
  assign multi_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_position_encoder.sv
// Randomized + directed bench for position_encoder
// against a cycle-level behavioural model.
module tb_position_encoder;

  localparam int NC = 9;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] btn_in;
  logic [3:0]  pos_out;
  logic        pos_valid;
  logic        pos_ready;
  logic        multi_err;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  position_encoder #(
    .NUM_CELLS       (NC),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .btn_in    (btn_in),
    .pos_out   (pos_out),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .multi_err (multi_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: buttons seen two edges late; a move is a single legal
  // button seen on DB+1 consecutive samples while enabled.
  int hist[$];
  int md_phase;   // 0 waiting, 1 settling, 2 offering, 3 awaiting release
  int md_seen;
  int md_held;
  int md_pos;
  bit md_err;

  always @(posedge clk) begin
    int s, m;
    if (!rst_n) begin
      hist = '{0, 0};
      md_phase = 0; md_seen = 0; md_held = 0;
      md_pos = 0; md_err = 0;
    end else begin
      s = hist.pop_front();
      hist.push_back(int'(btn_in));
      m = s % (1 << NC);
      md_err = 0;
      case (md_phase)
        0: if (enable && m != 0) begin
          if ($countones(m) == 1) begin
            md_held = m; md_seen = 0; md_phase = 1;
          end else begin
            md_err = 1; md_phase = 3;
          end
        end
        1: if (!enable || m != md_held) md_phase = 0;
           else if (md_seen == DB - 1) begin
             md_pos = $clog2(md_held); md_phase = 2;
           end else md_seen++;
        2: if (pos_ready) md_phase = 3;
        3: if (m == 0) md_phase = 0;
        default: md_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk("valid", int'(pos_valid), int'(md_phase == 2));
    chk("busy", int'(busy), int'(md_phase != 0));
    chk("merr", int'(multi_err), int'(md_err));
    chk("pos", int'(pos_out), md_pos);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pos_valid && n < 40);
    if (!pos_valid) chk("timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  int n, cnt;

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    btn_in = '0; pos_ready = 1'b1;
    tick();
    chk("rst_pos", int'(pos_out), 0);
    chk("rst_valid", int'(pos_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_merr", int'(multi_err), 0);
    rst_n = 1'b1;
    ticks(3);

    // 1: latency and single move while held
    btn_in = 16'h0010;
    wait_valid(n);
    chk("t1_lat", n, 3 + DB);
    chk("t1_pos", int'(pos_out), 4);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pos_valid) cnt++;
    end
    chk("t1_once", cnt, 0);
    btn_in = '0;
    ticks(5);
    chk("t1_idle", int'(busy), 0);

    // 2: bounce
    btn_in = 16'h0001; ticks(2);
    btn_in = '0;       ticks(1);
    btn_in = 16'h0001;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pos_valid) begin
        cnt++;
        chk("t2_pos", int'(pos_out), 0);
      end
    end
    chk("t2_moves", cnt, 1);
    btn_in = '0; ticks(5);

    // 3: multi press
    btn_in = 16'h0041;
    cnt = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(multi_err);
      n += int'(pos_valid);
    end
    chk("t3_err", cnt, 1);
    chk("t3_novalid", n, 0);
    btn_in = '0; ticks(4);
    btn_in = 16'h0100;
    wait_valid(n);
    chk("t3_pos", int'(pos_out), 8);
    btn_in = '0; ticks(5);

    // 4: backpressure
    pos_ready = 1'b0;
    btn_in = 16'h0020;
    wait_valid(n);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) btn_in = '0;
      tick();
      if (pos_valid && pos_out == 4'd5) cnt++;
    end
    chk("t4_held", cnt, 10);
    pos_ready = 1'b1;
    tick();
    chk("t4_drop", int'(pos_valid), 0);
    ticks(4);

    // 5: masking
    btn_in = 16'h8000;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(busy);
    end
    chk("t5_quiet", cnt, 0);
    btn_in = 16'h8002;
    wait_valid(n);
    chk("t5_pos", int'(pos_out), 1);
    btn_in = '0; ticks(5);

    // 6: reset in DEBOUNCE, reset in VALID, enable drop
    btn_in = 16'h0004;
    ticks(4);
    chk("t6_deb", int'(busy), 1);
    btn_in = '0;
    rst_n = 1'b0;
    tick();
    chk("t6a_busy", int'(busy), 0);
    chk("t6a_valid", int'(pos_valid), 0);
    rst_n = 1'b1;
    ticks(3);
    pos_ready = 1'b0;
    btn_in = 16'h0080;
    wait_valid(n);
    chk("t6b_pos", int'(pos_out), 7);
    btn_in = '0;
    rst_n = 1'b0;
    tick();
    chk("t6b_valid", int'(pos_valid), 0);
    chk("t6b_pos0", int'(pos_out), 0);
    chk("t6b_busy", int'(busy), 0);
    rst_n = 1'b1;
    pos_ready = 1'b1;
    ticks(3);
    btn_in = 16'h0008;
    ticks(4);
    enable = 1'b0;
    tick();
    chk("t6c_idle", int'(busy), 0);
    btn_in = '0; enable = 1'b1;
    ticks(4);

    // random segments
    for (int seg = 0; seg < 150; seg++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      case (kind)
        0, 1:    btn_in = '0;
        2, 3, 4: btn_in = 16'(1) << $urandom_range(0, NC - 1);
        5:       btn_in = 16'($urandom);
        6:       btn_in = 16'($urandom) & 16'hFE00;
        default: btn_in = (16'(1) << $urandom_range(0, NC - 1))
                          | (16'($urandom) & 16'hFE00);
      endcase
      enable = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 39) != 0);
      for (int c = 0; c < len; c++) begin
        pos_ready = 1'($urandom);
        tick();
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
